// File: rtl/Uop.sv
// Shared micro-op types for the memory stage: operation/size enums, the execute and
// memory pipeline records, the misaligned exception code and the stage FSM states.
package Uop;

    typedef enum logic [1:0] {
        OpNone  = 2'd0,
        OpLoad  = 2'd1,
        OpStore = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SizeB = 2'd0,
        SizeH = 2'd1,
        SizeW = 2'd2
    } mem_size_t;

    localparam logic [3:0] MISALIGNED = 4'd4;

    typedef struct packed {
        mem_op_t     op;
        mem_size_t   size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdVal;
        logic [3:0]  flags;
        logic        flagsValid;
        logic        exValid;
        logic [3:0]  ex;
    } execute_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rdVal;
        logic [3:0]  flags;
        logic        flagsValid;
        logic        exValid;
        logic [3:0]  ex;
        logic        memNack;
    } memory_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2
    } mem_state_t;

    function automatic logic is_misaligned(mem_size_t size, logic [1:0] addr_lo);
        return ((size == SizeH) && addr_lo[0]) || ((size == SizeW) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute->memory->writeback handshake plus the data-memory bus.
// master is the memory stage's view; slave is the surrounding pipeline and bus.
interface memory_stage_if;
    import Uop::*;

    logic        in_valid;
    logic        in_stall;
    execute_t    in_uop;
    logic        flush;
    logic        out_valid;
    logic        out_stall;
    memory_t     out_uop;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        dmem_nack;
    logic [31:0] dmem_rdata;

    modport master (
        input  in_valid, in_uop, flush, out_stall, dmem_ack, dmem_nack, dmem_rdata,
        output in_stall, out_valid, out_uop, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
    );

    modport slave (
        output in_valid, in_uop, flush, out_stall, dmem_ack, dmem_nack, dmem_rdata,
        input  in_stall, out_valid, out_uop, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane handling: byte enables and replicated store data for the
// naturally aligned lane, and lane extraction with zero/sign extension for loads.
module mem_lane_align
    import Uop::*;
(
    input  mem_size_t   i_size,
    input  logic        i_sign,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_off;
    logic [31:0] w_shifted;

    // Offsets are truncated to natural alignment, so a misaligned access lands on its lane.
    always_comb begin
        w_off   = 2'b00;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SizeB: begin
                w_off   = i_addr_lo;
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SizeH: begin
                w_off   = {i_addr_lo[1], 1'b0};
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_off   = 2'b00;
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    assign w_shifted = i_rdata >> {w_off, 3'b000};

    always_comb begin
        o_rdata = w_shifted;
        case (i_size)
            SizeB:   o_rdata = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
            SizeH:   o_rdata = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes non-memory uops through in one cycle and runs loads/stores
// on the data bus. Define MEM_MISALIGN_EX_EN to trap misaligned accesses instead of truncating.
module memory_stage
    import Uop::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    memory_stage_if.master bus
);

    mem_state_t       r_state;
    logic             r_out_valid;
    memory_t          r_out_uop;
    logic             r_dmem_req;
    execute_t         r_uop;

    logic             w_mis_ex;
    logic             w_fast;
    logic             w_resp;
    memory_t          w_fast_uop;
    memory_t          w_resp_uop;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [XLEN-1:0]  w_load_data;

`ifdef MEM_MISALIGN_EX_EN
    assign w_mis_ex = (bus.in_uop.op != OpNone) &&
                      is_misaligned(bus.in_uop.size, bus.in_uop.addr[1:0]);
`else
    assign w_mis_ex = 1'b0;
`endif

    assign w_fast = (bus.in_uop.op == OpNone) || bus.in_uop.exValid || w_mis_ex;
    assign w_resp = bus.dmem_ack | bus.dmem_nack;

    mem_lane_align u_lane_align (
        .i_size    (r_uop.size),
        .i_sign    (r_uop.sign),
        .i_addr_lo (r_uop.addr[1:0]),
        .i_wdata   (r_uop.wdata),
        .i_rdata   (bus.dmem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_load_data)
    );

    always_comb begin
        w_fast_uop.rd         = bus.in_uop.rd;
        w_fast_uop.rdVal      = bus.in_uop.rdVal;
        w_fast_uop.flags      = bus.in_uop.flags;
        w_fast_uop.flagsValid = bus.in_uop.flagsValid;
        w_fast_uop.exValid    = bus.in_uop.exValid | w_mis_ex;
        // An exception already raised upstream keeps its own code.
        w_fast_uop.ex         = (w_mis_ex && !bus.in_uop.exValid) ? MISALIGNED : bus.in_uop.ex;
        w_fast_uop.memNack    = 1'b0;
    end

    always_comb begin
        w_resp_uop.rd         = r_uop.rd;
        w_resp_uop.rdVal      = r_uop.rdVal;
        w_resp_uop.flags      = r_uop.flags;
        w_resp_uop.flagsValid = r_uop.flagsValid;
        w_resp_uop.exValid    = r_uop.exValid;
        w_resp_uop.ex         = r_uop.ex;
        w_resp_uop.memNack    = bus.dmem_nack;
        if ((r_uop.op == OpLoad) && !bus.dmem_nack) begin
            w_resp_uop.rdVal = w_load_data;
        end
    end

    // Datapath registers (r_uop, r_out_uop) deliberately have no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_dmem_req  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.flush) begin
                        r_out_valid <= 1'b0;
                    end else if (!bus.out_stall) begin
                        if (bus.in_valid && w_fast) begin
                            r_out_valid <= 1'b1;
                            r_out_uop   <= w_fast_uop;
                        end else if (bus.in_valid) begin
                            r_uop       <= bus.in_uop;
                            r_dmem_req  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_state     <= StBusy;
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                StBusy: begin
                    if (bus.flush) begin
                        if (w_resp) begin
                            r_dmem_req <= 1'b0;
                            r_state    <= StIdle;
                        end else begin
                            r_state <= StDrain;
                        end
                    end else if (w_resp) begin
                        r_out_valid <= 1'b1;
                        r_out_uop   <= w_resp_uop;
                        r_dmem_req  <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                StDrain: begin
                    if (w_resp) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= StIdle;
                    end
                end
                default: begin
                    r_dmem_req <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_stall   = (bus.in_valid & bus.out_stall) | (r_state != StIdle);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_uop    = r_out_uop;
    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = (r_uop.op == OpStore);
    assign bus.dmem_addr  = {r_uop.addr[31:2], 2'b00};
    assign bus.dmem_be    = w_be;
    assign bus.dmem_wdata = w_wdata;

endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized bench for memory_stage with a byte-level reference model.
module tb_memory_stage;
    import Uop::*;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_be;
    int          last_stalls;
    logic        seen_valid;
    execute_t    u;

    always #5 clk = ~clk;

    memory_stage_if bus ();

    memory_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(mem_size_t s);
        case (s)
            SizeB:   return 1;
            SizeH:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_off(execute_t x);
        int n = nbytes(x.size);
        return (int'(x.addr[1:0]) / n) * n;
    endfunction

    function automatic bit is_fast(execute_t x);
        bit mis = 1'b0;
`ifdef MEM_MISALIGN_EX_EN
        mis = (x.op != OpNone) && ((int'(x.addr[1:0]) % nbytes(x.size)) != 0);
`endif
        return (x.op == OpNone) || x.exValid || mis;
    endfunction

    function automatic logic [3:0] exp_be(execute_t x);
        logic [3:0] be;
        int n = nbytes(x.size);
        int off = lane_off(x);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(execute_t x);
        logic [31:0] w;
        int n = nbytes(x.size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = x.wdata[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(execute_t x, logic [31:0] rdata);
        logic [31:0] v = '0;
        int n = nbytes(x.size);
        int off = lane_off(x);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off + i) +: 8];
        if (x.sign && v[8*n - 1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic memory_t exp_out(execute_t x, bit nack, logic [31:0] rdata);
        memory_t m;
        m.rd         = x.rd;
        m.rdVal      = x.rdVal;
        m.flags      = x.flags;
        m.flagsValid = x.flagsValid;
        m.exValid    = x.exValid;
        m.ex         = x.ex;
        m.memNack    = 1'b0;
        if (is_fast(x)) begin
            if (!x.exValid && (x.op != OpNone)) begin
                m.exValid = 1'b1;
                m.ex      = MISALIGNED;
            end
        end else begin
            m.memNack = nack;
            if (!nack && (x.op == OpLoad)) m.rdVal = exp_load(x, rdata);
        end
        return m;
    endfunction

    function automatic execute_t mk(mem_op_t op, mem_size_t size, logic sign, logic [31:0] addr,
                                    logic [31:0] wdata, logic [4:0] rd, logic [31:0] rdval);
        execute_t x;
        x.op = op;
        x.size = size;
        x.sign = sign;
        x.addr = addr;
        x.wdata = wdata;
        x.rd = rd;
        x.rdVal = rdval;
        x.flags = 4'h0;
        x.flagsValid = 1'b0;
        x.exValid = 1'b0;
        x.ex = 4'h0;
        return x;
    endfunction

    function automatic execute_t rand_uop();
        execute_t x;
        x.op = mem_op_t'($urandom_range(0, 2));
        x.size = mem_size_t'($urandom_range(0, 2));
        x.sign = 1'($urandom_range(0, 1));
        x.addr = $urandom;
        x.wdata = $urandom;
        x.rd = 5'($urandom);
        x.rdVal = $urandom;
        x.flags = 4'($urandom);
        x.flagsValid = 1'($urandom_range(0, 1));
        x.exValid = ($urandom_range(0, 9) == 0);
        x.ex = 4'($urandom);
        return x;
    endfunction

    task automatic drive_txn(input execute_t x, input int waits, input bit nack,
                             input logic [31:0] rdata);
        memory_t exp;
        int stalls;
        exp = exp_out(x, nack, rdata);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_uop = x;
        @(negedge clk);
        check("accept_in_stall", 64'(bus.in_stall), 64'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (is_fast(x)) begin
            @(negedge clk);
            check("fast_no_req", 64'(bus.dmem_req), 64'(0));
            check("fast_valid", 64'(bus.out_valid), 64'(1));
            check("fast_uop", 64'(bus.out_uop), 64'(exp));
            last_stalls = 0;
        end else begin
            stalls = 0;
            for (int k = 0; k <= waits; k++) begin
                if (k == waits) begin
                    bus.dmem_ack = !nack;
                    bus.dmem_nack = nack;
                    bus.dmem_rdata = rdata;
                end
                @(negedge clk);
                if (k == 0) begin
                    last_addr = bus.dmem_addr;
                    last_be = bus.dmem_be;
                    last_wdata = bus.dmem_wdata;
                    check("bus_addr", 64'(bus.dmem_addr), 64'(x.addr - (x.addr % 4)));
                    check("bus_we", 64'(bus.dmem_we), 64'(x.op == OpStore));
                    check("bus_be", 64'(bus.dmem_be), 64'(exp_be(x)));
                    if (x.op == OpStore) begin
                        check("bus_wdata", 64'(bus.dmem_wdata), 64'(exp_wdata(x)));
                    end
                end
                check("busy_req", 64'(bus.dmem_req), 64'(1));
                check("busy_no_valid", 64'(bus.out_valid), 64'(0));
                if (bus.in_stall) stalls++;
                @(posedge clk); #1;
            end
            bus.dmem_ack = 1'b0;
            bus.dmem_nack = 1'b0;
            @(negedge clk);
            check("stall_cycles", 64'(stalls), 64'(waits + 1));
            check("resp_valid", 64'(bus.out_valid), 64'(1));
            check("resp_uop", 64'(bus.out_uop), 64'(exp));
            check("idle_req", 64'(bus.dmem_req), 64'(0));
            check("idle_in_stall", 64'(bus.in_stall), 64'(0));
            last_stalls = stalls;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_uop = '0;
        bus.flush = 1'b0;
        bus.out_stall = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_nack = 1'b0;
        bus.dmem_rdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_dmem_req", 64'(bus.dmem_req), 64'(0));
        check("rst_in_stall", 64'(bus.in_stall), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU pass-through
        drive_txn(mk(OpNone, SizeW, 1'b0, 32'h0, 32'h0, 5'd5, 32'h1234), 0, 1'b0, 32'h0);
        check("alu_rdval", 64'(bus.out_uop.rdVal), 64'(32'h1234));
        check("alu_rd", 64'(bus.out_uop.rd), 64'(5));
        check("alu_nack", 64'(bus.out_uop.memNack), 64'(0));

        // Signed byte load from the top lane with three wait cycles
        drive_txn(mk(OpLoad, SizeB, 1'b1, 32'h103, 32'h0, 5'd3, 32'h0), 3, 1'b0, 32'h8000_0000);
        check("lb_rdval", 64'(bus.out_uop.rdVal), 64'(32'hFFFF_FF80));
        check("lb_be", 64'(last_be), 64'(4'b1000));
        check("lb_stalls", 64'(last_stalls), 64'(4));

        // Halfword store to the upper half
        drive_txn(mk(OpStore, SizeH, 1'b0, 32'h202, 32'hBEEF, 5'd0, 32'h55), 1, 1'b0, 32'h0);
        check("sh_addr", 64'(last_addr), 64'(32'h200));
        check("sh_be", 64'(last_be), 64'(4'b1100));
        check("sh_wdata", 64'(last_wdata), 64'(32'hBEEF_BEEF));
        check("sh_rdval", 64'(bus.out_uop.rdVal), 64'(32'h55));

        // Nacked load
        drive_txn(mk(OpLoad, SizeW, 1'b0, 32'h300, 32'h0, 5'd9, 32'h0), 0, 1'b1, 32'h0);
        check("nack_flag", 64'(bus.out_uop.memNack), 64'(1));

        // Flush in BUSY, ack two cycles later: drained with no output
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_uop = mk(OpLoad, SizeW, 1'b0, 32'h400, 32'h0, 5'd1, 32'h0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        seen_valid = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        seen_valid = seen_valid | bus.out_valid;
        check("drain_req", 64'(bus.dmem_req), 64'(1));
        check("drain_in_stall", 64'(bus.in_stall), 64'(1));
        @(posedge clk); #1;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        seen_valid = seen_valid | bus.out_valid;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("drain_done_req", 64'(bus.dmem_req), 64'(0));
        check("drain_done_idle", 64'(bus.in_stall), 64'(0));
        repeat (2) begin
            seen_valid = seen_valid | bus.out_valid;
            @(negedge clk);
        end
        check("drain_no_output", 64'(seen_valid), 64'(0));

        // Flush coinciding with ack: straight back to idle, no output
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_uop = mk(OpLoad, SizeW, 1'b0, 32'h500, 32'h0, 5'd2, 32'h0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        bus.dmem_ack = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("flush_ack_req", 64'(bus.dmem_req), 64'(0));
        check("flush_ack_idle", 64'(bus.in_stall), 64'(0));
        check("flush_ack_valid", 64'(bus.out_valid), 64'(0));

        // Flush in IDLE ignores the incoming uop and clears the output
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_uop = mk(OpNone, SizeW, 1'b0, 32'h0, 32'h0, 5'd4, 32'hA5A5);
        @(posedge clk); #1;
        bus.in_uop = mk(OpNone, SizeW, 1'b0, 32'h0, 32'h0, 5'd6, 32'h5A5A);
        bus.flush = 1'b1;
        @(negedge clk);
        check("pre_flush_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("idle_flush_valid", 64'(bus.out_valid), 64'(0));

        // out_stall holds the output and back-pressures a valid input
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_uop = mk(OpNone, SizeW, 1'b0, 32'h0, 32'h0, 5'd7, 32'hAAAA);
        @(posedge clk); #1;
        bus.in_uop = mk(OpNone, SizeW, 1'b0, 32'h0, 32'h0, 5'd8, 32'hBBBB);
        bus.out_stall = 1'b1;
        @(negedge clk);
        check("hold_in_stall", 64'(bus.in_stall), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_valid", 64'(bus.out_valid), 64'(1));
        check("hold_rdval", 64'(bus.out_uop.rdVal), 64'(32'hAAAA));
        @(posedge clk); #1;
        bus.out_stall = 1'b0;
        @(negedge clk);
        check("release_in_stall", 64'(bus.in_stall), 64'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("release_rdval", 64'(bus.out_uop.rdVal), 64'(32'hBBBB));

        // Misaligned word load
        u = mk(OpLoad, SizeW, 1'b0, 32'h101, 32'h0, 5'd10, 32'h77);
        drive_txn(u, 1, 1'b0, 32'hCAFE_F00D);
`ifdef MEM_MISALIGN_EX_EN
        check("mis_exvalid", 64'(bus.out_uop.exValid), 64'(1));
        check("mis_ex", 64'(bus.out_uop.ex), 64'(MISALIGNED));
`else
        check("mis_trunc_addr", 64'(last_addr), 64'(32'h100));
        check("mis_trunc_data", 64'(bus.out_uop.rdVal), 64'(32'hCAFE_F00D));
`endif

        // Reset abandons an outstanding request
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_uop = mk(OpStore, SizeW, 1'b0, 32'h600, 32'h1, 5'd0, 32'h0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_req", 64'(bus.dmem_req), 64'(0));
        check("rst_busy_stall", 64'(bus.in_stall), 64'(0));
        check("rst_busy_valid", 64'(bus.out_valid), 64'(0));

        for (int t = 0; t < 60; t++) begin
            drive_txn(rand_uop(), int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                      $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  execute-stage uop valid.
REQ-005 in_stall  out  1  upstream must hold its uop stable while high.
REQ-006 in_uop  in  execute_t  op (NONE/LOAD/STORE), size (B/H/W), sign, addr, wdata, rd, rdVal, flags, flagsValid, exValid, ex.
REQ-007 flush  in  1  kill the accepted and in-flight uop.
REQ-008 out_valid  out  1  memory_t uop valid toward writeback.
REQ-009 out_stall  in  1  writeback hold request.
REQ-010 out_uop  out  memory_t  rd, rdVal, flags, flagsValid, exValid, ex, memNack.
REQ-011 dmem_req/dmem_we  out  1/1  bus request and write strobe.
REQ-012 dmem_addr/dmem_wdata/dmem_be  out  32/32/4  word address (low 2 bits zero), lane-shifted data, byte enables.
REQ-013 dmem_ack/dmem_nack/dmem_rdata  in  1/1/32  single-cycle response pulses and read data.

Function
REQ-014 FSM states IDLE, BUSY and DRAIN.
REQ-015 IDLE, in_valid, op NONE or exValid, !out_stall: output register loads the uop with memNack=0 on the next edge (1-cycle latency).
REQ-016 IDLE, in_valid, op LOAD/STORE, !exValid, !out_stall: the request is captured into registers, the next state is BUSY and out_valid is 0 on the next cycle.
REQ-017 BUSY: dmem_req=1 with captured fields held stable until dmem_ack or dmem_nack.
REQ-018 BUSY, ack: output loads with LOAD rdVal = extracted lane (zero- or sign-extended per sign) or STORE rdVal = captured rdVal, then the FSM returns to IDLE.
REQ-019 BUSY, nack: output loads with memNack=1, then the FSM returns to IDLE.
REQ-020 The response is always accepted because the output is empty during BUSY.
REQ-021 in_stall = (in_valid & out_stall) | state!=IDLE.
REQ-022 With out_stall high, the output register holds its value.
REQ-023 Byte enables: B=0001<<addr[1:0], H=0011<<addr[1:0], W=1111.
REQ-024 wdata is replicated into the selected lanes.
REQ-025 flush in IDLE: in_valid is ignored for that cycle and out_valid clears on the next edge.
REQ-026 flush in BUSY: the FSM enters DRAIN.
REQ-027 DRAIN: dmem_req stays high until ack/nack, the response is discarded, the FSM returns to IDLE and no output is produced.
REQ-028 Simultaneous flush and ack in BUSY: the response is discarded and the FSM returns directly to IDLE.

Reset
REQ-029 rst forces IDLE, out_valid=0, dmem_req=0 and in_stall=0, and abandons any outstanding request.
REQ-030 The bus owner resets concurrently.
REQ-031 Datapath registers (rd, rdVal, captured addr/wdata) are not reset.

Configuration
REQ-032 The macro MEM_MISALIGN_EX_EN controls misalignment handling (H with addr[0]=1, W with addr[1:0]!=0).
REQ-033 With MEM_MISALIGN_EX_EN defined, a misaligned mem uop issues no bus request; it completes through the 1-cycle path with exValid=1 and ex=MISALIGNED.
REQ-034 Without MEM_MISALIGN_EX_EN, misaligned addresses are truncated to natural alignment and the access proceeds.

Structure
REQ-035 mem_op_t, mem_size_t, execute_t, memory_t and the MISALIGNED ex code live in package Uop.
REQ-036 One sub-module, mem_lane_align, contains the combinational lane shift, byte-enable generation and load extension.

Verification
REQ-037 ALU uop rd=5, rdVal=0x1234 -> out_valid the next cycle with rdVal=0x1234, memNack=0.
REQ-038 LOAD B signed at addr 0x103, rdata=0x80000000, ack after 3 wait cycles -> be=1000, out rdVal=0xFFFFFF80, in_stall high for 4 cycles.
REQ-039 STORE H at addr 0x202, wdata=0xBEEF -> dmem_addr=0x200, be=1100, dmem_wdata=0xBEEFBEEF.
REQ-040 LOAD answered by nack -> out memNack=1.
REQ-041 flush in BUSY then ack two cycles later -> no out_valid, FSM returns to IDLE.
REQ-042 LOAD W at 0x101 -> exValid=1, no dmem_req with MEM_MISALIGN_EX_EN; addr 0x100 read without it.
